// File: rtl/ram_dump_uart.sv
// ram_dump_uart: after the CPU raises eoe, reads RAM words 0..WORDS-1 and
// sends each one over an 8N1 UART line as two bytes, high byte first.
// Optional build macro UART_PARITY_EN adds an even-parity bit after data
// bit 7, giving an 11-bit frame.
module ram_dump_uart #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 16,
    parameter int WORDS        = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              eoe,
    input  logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              done
);

`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        FRAME_LAST = 4'(FRAME_BITS - 1);
    localparam logic [ADDR_W-1:0] WORD_LAST  = ADDR_W'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        LOAD,
        TX,
        NEXT,
        FIN
    } state_t;

    state_t                  state_reg, state_next;
    logic                    eoe_q_reg;
    logic [ADDR_W-1:0]       word_idx_reg;
    logic                    byte_sel_reg;
    logic [15:0]             word_reg;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [CNT_W-1:0]        clk_cnt_reg;
    logic [3:0]              bit_cnt_reg;
    logic                    tx_reg, tx_next;

    logic                    start;
    logic                    bit_end;
    logic                    frame_end;
    logic [7:0]              tx_byte;
    logic [FRAME_BITS-1:0]   frame;

    assign start     = eoe & ~eoe_q_reg;
    assign bit_end   = (clk_cnt_reg == BIT_LAST);
    assign frame_end = bit_end && (bit_cnt_reg == FRAME_LAST);

    // Byte select: 0 picks the high byte of the captured word, 1 the low byte.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte_mux
            assign tx_byte[gi] = byte_sel_reg ? word_reg[gi] : word_reg[gi + 8];
        end
    endgenerate

    // Frame is sent LSB first: start bit in bit 0, stop bit on top.
`ifdef UART_PARITY_EN
    assign frame = {1'b1, ^tx_byte, tx_byte, 1'b0};
`else
    assign frame = {1'b1, tx_byte, 1'b0};
`endif

    assign ram_addr = word_idx_reg;
    assign tx       = tx_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, Moore outputs and the next value of the registered tx line.
    always_comb begin
        state_next = state_reg;
        ram_rd_en  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                ram_rd_en  = 1'b1;
                state_next = WAIT;
            end
            WAIT: state_next = LOAD;
            LOAD: state_next = TX;
            TX: begin
                if (frame_end) begin
                    state_next = byte_sel_reg ? NEXT : LOAD;
                end
            end
            NEXT: state_next = (word_idx_reg == WORD_LAST) ? FIN : REQ;
            FIN: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        // tx follows the bit that will be on the line in the next state;
        // shift_reg[0] is always the bit currently being driven.
        tx_next = 1'b1;
        if (state_next == TX) begin
            if (state_reg == LOAD) begin
                tx_next = frame[0];
            end else if (bit_end) begin
                tx_next = shift_reg[1];
            end else begin
                tx_next = shift_reg[0];
            end
        end
    end

    // Datapath: edge detect, word capture, bit/baud counters, word index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            eoe_q_reg    <= 1'b0;
            word_idx_reg <= '0;
            byte_sel_reg <= 1'b0;
            word_reg     <= '0;
            shift_reg    <= '0;
            clk_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            tx_reg       <= 1'b1;
        end else begin
            eoe_q_reg <= eoe;
            tx_reg    <= tx_next;
            case (state_reg)
                WAIT: word_reg <= ram_data[15:0];
                LOAD: begin
                    shift_reg   <= frame;
                    clk_cnt_reg <= '0;
                    bit_cnt_reg <= '0;
                end
                TX: begin
                    if (bit_end) begin
                        clk_cnt_reg <= '0;
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        shift_reg   <= {1'b1, shift_reg[FRAME_BITS-1:1]};
                        if (frame_end && !byte_sel_reg) begin
                            byte_sel_reg <= 1'b1;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
                NEXT: begin
                    byte_sel_reg <= 1'b0;
                    if (word_idx_reg != WORD_LAST) begin
                        word_idx_reg <= word_idx_reg + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dump_uart.sv
// Directed testbench for ram_dump_uart (CLKS_PER_BIT=4, WORDS=4).
// Honours UART_PARITY_EN when compiled with it.
module tb_ram_dump_uart;

    localparam int CPB    = 4;
    localparam int ADDR_W = 6;
    localparam int WORDS  = 4;
`ifdef UART_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              eoe = 1'b0;
    logic [15:0]       ram_data = 16'h0000;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic              tx;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [4];
    logic [7:0]  exp_bytes [8] = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h12, 8'h34};
    logic        exp_par   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    logic [7:0]        rx_q[$];
    logic              rx_par_q[$];
    logic [ADDR_W-1:0] rd_q[$];
    int                frame_err = 0;

    ram_dump_uart #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (ADDR_W),
        .DATA_W      (16),
        .WORDS       (WORDS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .eoe      (eoe),
        .ram_data (ram_data),
        .ram_addr (ram_addr),
        .ram_rd_en(ram_rd_en),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    initial forever #5 clk = ~clk;

    // RAM model with one-cycle read latency.
    initial begin
        mem[0] = 16'hA55A;
        mem[1] = 16'h0001;
        mem[2] = 16'hFF00;
        mem[3] = 16'h1234;
    end
    always @(posedge clk) begin
        if (ram_rd_en) ram_data <= mem[ram_addr[1:0]];
    end

    // Read-strobe monitor.
    initial forever begin
        @(negedge clk);
        if (reset === 1'b1 && ram_rd_en === 1'b1) rd_q.push_back(ram_addr);
    end

    // UART receiver: samples mid-bit, abandons a frame when reset is low.
    initial begin
        int  rx_cnt;
        int  rx_idx;
        bit  rx_active;
        logic [7:0] rx_byte;
        logic rx_par;
        rx_cnt = 0;
        rx_active = 0;
        rx_byte = 8'h00;
        rx_par = 1'b0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                rx_active = 0;
            end else if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % CPB == CPB / 2) begin
                    rx_idx = rx_cnt / CPB;
                    if (rx_idx == 0) begin
                        if (tx !== 1'b0) frame_err++;
                    end else if (rx_idx <= 8) begin
                        rx_byte[rx_idx-1] = tx;
                    end else if (rx_idx == FRAME - 1) begin
                        if (tx !== 1'b1) frame_err++;
                        rx_q.push_back(rx_byte);
                        rx_par_q.push_back(rx_par);
                        rx_active = 0;
                        $display("[rx] byte %0d = %02h", rx_q.size() - 1, rx_byte);
                    end else begin
                        rx_par = tx;
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        rx_q.delete();
        rx_par_q.delete();
        rd_q.delete();
        frame_err = 0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, n);
        end
    endtask

    // Checks a whole dump: 8 bytes in order, clean frames, 4 strobes 0..3.
    task automatic check_stream(input string name);
        checks++;
        if (rx_q.size() != 8) begin
            errors++;
            $display("FAIL %s_byte_count: got %0d, required 8", name, rx_q.size());
        end
        for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_bytes[i]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %02h, required %02h", name, i, rx_q[i], exp_bytes[i]);
            end
`ifdef UART_PARITY_EN
            checks++;
            if (rx_par_q[i] !== exp_par[i]) begin
                errors++;
                $display("FAIL %s_parity%0d: got %b, required %b", name, i, rx_par_q[i], exp_par[i]);
            end
`endif
        end
        checks++;
        if (frame_err != 0) begin
            errors++;
            $display("FAIL %s_framing: %0d bad start/stop bits, required 0", name, frame_err);
        end
        checks++;
        if (rd_q.size() != WORDS) begin
            errors++;
            $display("FAIL %s_strobe_count: got %0d, required %0d", name, rd_q.size(), WORDS);
        end
        for (int i = 0; i < WORDS && i < rd_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== ADDR_W'(i)) begin
                errors++;
                $display("FAIL %s_strobe_addr%0d: got %0d, required %0d", name, i, rd_q[i], i);
            end
        end
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL %s_end_state: busy=%b tx=%b, required 0 1", name, busy, tx);
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b0;
        eoe = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ram_rd_en !== 1'b0 || ram_addr !== '0) begin
            errors++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b rd_en=%b addr=%0d, required 1 0 0 0 0",
                     tx, busy, done, ram_rd_en, ram_addr);
        end
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, done, ram_rd_en} !== 4'b1000) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL idle_cycle%0d: tx/busy/done/rd_en=%b, required 1000", i, {tx, busy, done, ram_rd_en});
            end
        end
        $display("[test_reset] idle hold of 100 cycles done");
    endtask

    task automatic test_start();
        clear_logs();
        eoe = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ram_rd_en !== 1'b1 || ram_addr !== '0) begin
            errors++;
            $display("FAIL start_request: busy=%b rd_en=%b addr=%0d, required 1 1 0", busy, ram_rd_en, ram_addr);
        end
        $display("[test_start] eoe raised");
    endtask

    task automatic test_bit_timing();
        logic [10:0] exp_frame;
        int n;
        int bad;
`ifdef UART_PARITY_EN
        exp_frame = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
        exp_frame = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL first_start_bit: tx=%b after %0d cycles, required 0", tx, n);
        end else begin
            bad = 0;
            for (int i = 0; i < FRAME * CPB; i++) begin
                if (i > 0) @(negedge clk);
                checks++;
                if (tx !== exp_frame[i / CPB]) begin
                    errors++;
                    bad++;
                    if (bad < 4)
                        $display("FAIL bit_timing_cycle%0d: tx=%b, required %b", i, tx, exp_frame[i / CPB]);
                end
            end
            @(negedge clk);
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL inter_byte_load: tx=%b, required 1", tx);
            end
            @(negedge clk);
            checks++;
            if (tx !== 1'b0) begin
                errors++;
                $display("FAIL second_start_bit: tx=%b, required 0", tx);
            end
        end
        $display("[test_bit_timing] first frame checked cycle by cycle");
    endtask

    task automatic test_full_dump();
        wait_done("dump");
        check_stream("dump");
        repeat (200) @(negedge clk);
        checks++;
        if (rd_q.size() != WORDS || rx_q.size() != 8 || done !== 1'b1) begin
            errors++;
            $display("FAIL held_eoe_restart: strobes=%0d bytes=%0d done=%b, required 4 8 1",
                     rd_q.size(), rx_q.size(), done);
        end
        $display("[test_full_dump] 8 bytes received");
    endtask

    task automatic test_ignore_after_done();
        eoe = 1'b0;
        repeat (3) @(negedge clk);
        eoe = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (rd_q.size() != WORDS || rx_q.size() != 8 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL edge_after_done: strobes=%0d bytes=%0d done=%b busy=%b, required 4 8 1 0",
                     rd_q.size(), rx_q.size(), done, busy);
        end
        $display("[test_ignore_after_done] second edge ignored");
    endtask

    task automatic test_reset_mid();
        int n;
        reset = 1'b0;
        eoe = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_logs();
        @(negedge clk);
        eoe = 1'b1;
        n = 0;
        while (rx_q.size() < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_q.size() < 2) begin
            errors++;
            $display("FAIL mid_reset_setup: bytes=%0d, required 2", rx_q.size());
        end
        repeat (20) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ram_rd_en !== 1'b0 || ram_addr !== '0) begin
            errors++;
            $display("FAIL mid_reset_state: tx=%b busy=%b done=%b rd_en=%b addr=%0d, required 1 0 0 0 0",
                     tx, busy, done, ram_rd_en, ram_addr);
        end
        eoe = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clear_logs();
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL no_restart_without_edge: busy=%b strobes=%0d, required 0 0", busy, rd_q.size());
        end
        $display("[test_reset_mid] reset during byte 3 forced idle");
    endtask

    task automatic test_restart_ignore_busy();
        clear_logs();
        eoe = 1'b1;
        repeat (100) @(negedge clk);
        eoe = 1'b0;
        repeat (3) @(negedge clk);
        eoe = 1'b1;
        wait_done("restart");
        check_stream("restart");
        $display("[test_restart_ignore_busy] restart produced full stream");
    endtask

    task automatic test_eoe_at_release();
        reset = 1'b0;
        eoe = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        clear_logs();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ram_rd_en !== 1'b1 || ram_addr !== '0) begin
            errors++;
            $display("FAIL eoe_at_release: busy=%b rd_en=%b addr=%0d, required 1 1 0", busy, ram_rd_en, ram_addr);
        end
        wait_done("release");
        check_stream("release");
        $display("[test_eoe_at_release] dump started straight out of reset");
    endtask

    initial begin
        test_reset();
        test_start();
        test_bit_timing();
        test_full_dump();
        test_ignore_after_done();
        test_reset_mid();
        test_restart_ignore_busy();
        test_eoe_at_release();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
